// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and constants for the stack pop responder
package stack_pkg;

    localparam int STACK_W_DEF = 32;

    typedef struct packed {
        logic                   err;
        logic [STACK_W_DEF-1:0] data;
    } stack_rsp_t;

    typedef struct packed {
        logic vld;
        logic err;
    } stack_tok_t;

    // One slot per read in flight plus one for the response being held at the head.
    function automatic int stack_depth(input int rd_lat);
        return rd_lat + 1;
    endfunction

endpackage

// File: rtl/stack_rsp_fifo.sv
// rtl/stack_rsp_fifo.sv - small in-order valid/ready response FIFO with occupancy output
module stack_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 33,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic [DW-1:0] i_tdata,
    input  logic          i_tvalid,
    output logic          o_tready,
    output logic [DW-1:0] o_tdata,
    output logic          o_tvalid,
    input  logic          i_tready,
    output logic [OW-1:0] o_occ
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [OW-1:0] r_occ;
    logic          w_wr;
    logic          w_rd;

    // A full FIFO may still take a write when its head leaves in the same cycle.
    assign o_tvalid = (r_occ != '0);
    assign o_tready = (r_occ != OW'(DEPTH)) | i_tready;
    assign w_wr     = i_tvalid & o_tready;
    assign w_rd     = o_tvalid & i_tready;
    assign o_tdata  = o_tvalid ? r_mem[r_rd_ptr] : '0;
    assign o_occ    = r_occ;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/stack_pop_rsp.sv
// rtl/stack_pop_rsp.sv - pop request responder: shadow count, credit gate, read delay pipe, response FIFO
module stack_pop_rsp
    import stack_pkg::*;
#(
    parameter int N      = 16,
    parameter int W      = 32,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             i_push,
    input  logic             i_pop_req_vld,
    output logic             o_pop_req_rdy,
    output logic             o_cntrl_pop,
    input  logic [W-1:0]     i_mem_rdata,
    output logic             o_rsp_vld,
    input  logic             i_rsp_rdy,
    output logic [W-1:0]     o_rsp_data,
    output logic             o_rsp_err,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int DEPTH = stack_depth(RD_LAT);
    localparam int OW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic         err;
        logic [W-1:0] data;
    } rsp_t;

    logic [CNT_W-1:0] r_count;
    stack_tok_t       r_pipe [RD_LAT];
    stack_tok_t       w_exit;
    logic [OW-1:0]    w_inflight;
    logic [OW-1:0]    w_occ;
    logic [OW:0]      w_used;
    logic             w_accept;
    logic             w_has;
    logic             w_rsp_fire;
    logic             w_fifo_wr_rdy;
    rsp_t             w_wr_rsp;
    rsp_t             w_head;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + OW'(r_pipe[i].vld);
        end
    end

    // A response leaving the FIFO this cycle frees its slot for a new accept, sustaining one pop per cycle.
    assign w_rsp_fire    = o_rsp_vld & i_rsp_rdy;
    assign w_used        = {1'b0, w_inflight} + {1'b0, w_occ} - (OW + 1)'(w_rsp_fire);
    assign o_pop_req_rdy = arst_n & ~i_push & (w_used < (OW + 1)'(DEPTH));
    assign w_accept      = i_pop_req_vld & o_pop_req_rdy;
    assign w_has         = (r_count != '0);
    assign o_cntrl_pop   = w_accept & w_has;

    assign o_empty = ~w_has;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_count <= '0;
        end else if (i_push) begin
            if (r_count != CNT_W'(N)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (o_cntrl_pop) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Empty-stack pops still travel the pipe so their error responses stay ordered behind real reads.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= '{vld: w_accept, err: w_accept & ~w_has};
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_exit   = r_pipe[RD_LAT-1];
    assign w_wr_rsp = '{err: w_exit.err, data: w_exit.err ? '0 : i_mem_rdata};

    stack_rsp_fifo #(
        .DEPTH (DEPTH),
        .DW    ($bits(rsp_t))
    ) u_rsp_fifo (
        .clk      (clk),
        .arst_n   (arst_n),
        .i_tdata  (w_wr_rsp),
        .i_tvalid (w_exit.vld),
        .o_tready (w_fifo_wr_rdy),
        .o_tdata  (w_head),
        .o_tvalid (o_rsp_vld),
        .i_tready (i_rsp_rdy),
        .o_occ    (w_occ)
    );

    assign o_rsp_err  = w_head.err;
    assign o_rsp_data = w_head.data;

    a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n) w_exit.vld |-> w_fifo_wr_rdy);
    a_pop_legal:   assert property (@(posedge clk) disable iff (!arst_n) o_cntrl_pop |-> (!i_push && r_count != '0));
    a_count_max:   assert property (@(posedge clk) disable iff (!arst_n) r_count <= CNT_W'(N));

endmodule

// File: tb/tb_stack_pop_rsp.sv
// tb/tb_stack_pop_rsp.sv - table-driven and directed checks of stack_pop_rsp at RD_LAT=1 and RD_LAT=3
module tb_stack_pop_rsp;

    logic       clk;
    int         n_cmp;
    int         n_fail;

    logic       rst_n, push, pvld, rrdy;
    logic [7:0] mrd;
    logic       prdy, cpop, rvld, rerr, empty;
    logic [7:0] rdata;
    logic [2:0] cnt;

    logic       rst3, push3, pvld3, rrdy3;
    logic [7:0] mrd3;
    logic       prdy3, cpop3, rvld3, rerr3, empty3;
    logic [7:0] rdata3;
    logic [2:0] cnt3;

    stack_pop_rsp #(.N(4), .W(8), .RD_LAT(1)) u_dut (
        .clk(clk), .arst_n(rst_n), .i_push(push),
        .i_pop_req_vld(pvld), .o_pop_req_rdy(prdy), .o_cntrl_pop(cpop),
        .i_mem_rdata(mrd), .o_rsp_vld(rvld), .i_rsp_rdy(rrdy),
        .o_rsp_data(rdata), .o_rsp_err(rerr), .o_empty(empty), .o_count(cnt)
    );

    stack_pop_rsp #(.N(4), .W(8), .RD_LAT(3)) u_dut3 (
        .clk(clk), .arst_n(rst3), .i_push(push3),
        .i_pop_req_vld(pvld3), .o_pop_req_rdy(prdy3), .o_cntrl_pop(cpop3),
        .i_mem_rdata(mrd3), .o_rsp_vld(rvld3), .i_rsp_rdy(rrdy3),
        .o_rsp_data(rdata3), .o_rsp_err(rerr3), .o_empty(empty3), .o_count(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, push, pvld, rrdy;
        logic [7:0] mrd;
        logic       prdy, cpop, rvld, rerr;
        logic [7:0] rdata;
        logic       empty;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic pu, input logic pv, input logic rr, input logic [7:0] m,
                       input logic ep, input logic ec, input logic ev, input logic ee,
                       input logic [7:0] ed, input logic em, input logic [2:0] en);
        vec_t v;
        v.rst_n = r;  v.push = pu; v.pvld = pv; v.rrdy = rr; v.mrd = m;
        v.prdy = ep;  v.cpop = ec; v.rvld = ev; v.rerr = ee; v.rdata = ed;
        v.empty = em; v.cnt = en;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drv3(input logic r, input logic pu, input logic pv, input logic rr, input logic [7:0] m);
        @(negedge clk);
        rst3 = r; push3 = pu; pvld3 = pv; rrdy3 = rr; mrd3 = m;
        #2;
    endtask

    initial begin
        int acc;
        n_cmp = 0; n_fail = 0;
        rst_n = 0; push = 0; pvld = 0; rrdy = 0; mrd = '0;
        rst3 = 0; push3 = 0; pvld3 = 0; rrdy3 = 0; mrd3 = '0;

        //   rst push pvld rrdy mrd     prdy cpop rvld rerr rdata  empty cnt
        add(0, 0, 1, 0, 8'h00,   0, 0, 0, 0, 8'h00, 1, 0);
        add(1, 0, 1, 1, 8'h00,   1, 0, 0, 0, 8'h00, 1, 0);
        add(1, 0, 0, 0, 8'h00,   1, 0, 0, 0, 8'h00, 1, 0);
        add(1, 0, 0, 1, 8'h00,   1, 0, 1, 1, 8'h00, 1, 0);
        add(1, 0, 0, 0, 8'h00,   1, 0, 0, 0, 8'h00, 1, 0);
        add(1, 1, 0, 0, 8'h00,   0, 0, 0, 0, 8'h00, 1, 0);
        add(1, 1, 0, 0, 8'h00,   0, 0, 0, 0, 8'h00, 0, 1);
        add(1, 1, 0, 0, 8'h00,   0, 0, 0, 0, 8'h00, 0, 2);
        add(1, 0, 0, 0, 8'h00,   1, 0, 0, 0, 8'h00, 0, 3);
        add(1, 0, 1, 1, 8'h00,   1, 1, 0, 0, 8'h00, 0, 3);
        add(1, 0, 0, 0, 8'hA5,   1, 0, 0, 0, 8'h00, 0, 2);
        add(1, 0, 0, 1, 8'h00,   1, 0, 1, 0, 8'hA5, 0, 2);
        add(1, 0, 0, 1, 8'h00,   1, 0, 0, 0, 8'h00, 0, 2);
        add(1, 1, 1, 1, 8'h00,   0, 0, 0, 0, 8'h00, 0, 2);
        add(1, 0, 1, 1, 8'h00,   1, 1, 0, 0, 8'h00, 0, 3);
        add(1, 0, 0, 1, 8'h3C,   1, 0, 0, 0, 8'h00, 0, 2);
        add(1, 0, 0, 1, 8'h00,   1, 0, 1, 0, 8'h3C, 0, 2);
        add(1, 1, 0, 0, 8'h00,   0, 0, 0, 0, 8'h00, 0, 2);
        add(1, 1, 0, 0, 8'h00,   0, 0, 0, 0, 8'h00, 0, 3);
        add(1, 1, 0, 0, 8'h00,   0, 0, 0, 0, 8'h00, 0, 4);
        add(1, 0, 1, 0, 8'h00,   1, 1, 0, 0, 8'h00, 0, 4);
        add(1, 0, 1, 0, 8'h11,   1, 1, 0, 0, 8'h00, 0, 3);
        add(1, 0, 1, 0, 8'h22,   0, 0, 1, 0, 8'h11, 0, 2);
        add(1, 0, 1, 0, 8'h00,   0, 0, 1, 0, 8'h11, 0, 2);
        add(1, 0, 1, 1, 8'h00,   1, 1, 1, 0, 8'h11, 0, 2);
        add(1, 0, 0, 1, 8'h33,   1, 0, 1, 0, 8'h22, 0, 1);
        add(1, 0, 0, 1, 8'h00,   1, 0, 1, 0, 8'h33, 0, 1);
        add(1, 0, 0, 1, 8'h00,   1, 0, 0, 0, 8'h00, 0, 1);
        add(1, 0, 1, 1, 8'h00,   1, 1, 0, 0, 8'h00, 0, 1);
        add(1, 0, 1, 1, 8'h44,   1, 0, 0, 0, 8'h00, 1, 0);
        add(1, 0, 1, 1, 8'h00,   1, 0, 1, 0, 8'h44, 1, 0);
        add(1, 0, 1, 1, 8'h00,   1, 0, 1, 1, 8'h00, 1, 0);
        add(1, 0, 0, 1, 8'h00,   1, 0, 1, 1, 8'h00, 1, 0);
        add(1, 0, 0, 1, 8'h00,   1, 0, 1, 1, 8'h00, 1, 0);
        add(1, 0, 0, 1, 8'h00,   1, 0, 0, 0, 8'h00, 1, 0);
        add(0, 0, 1, 1, 8'h00,   0, 0, 0, 0, 8'h00, 1, 0);
        add(1, 0, 0, 0, 8'h00,   1, 0, 0, 0, 8'h00, 1, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; push = vecs[i].push; pvld = vecs[i].pvld;
            rrdy = vecs[i].rrdy; mrd = vecs[i].mrd;
            #2;
            chk($sformatf("r%0d.pop_req_rdy", i), 32'(prdy),  32'(vecs[i].prdy));
            chk($sformatf("r%0d.cntrl_pop", i),   32'(cpop),  32'(vecs[i].cpop));
            chk($sformatf("r%0d.rsp_vld", i),     32'(rvld),  32'(vecs[i].rvld));
            chk($sformatf("r%0d.rsp_err", i),     32'(rerr),  32'(vecs[i].rerr));
            chk($sformatf("r%0d.rsp_data", i),    32'(rdata), 32'(vecs[i].rdata));
            chk($sformatf("r%0d.empty", i),       32'(empty), 32'(vecs[i].empty));
            chk($sformatf("r%0d.count", i),       32'(cnt),   32'(vecs[i].cnt));
        end

        // RD_LAT=3: one real pop followed by two empty-stack pops, ordering preserved
        drv3(1, 1, 0, 0, 8'h00); chk("l3.cnt_pre", 32'(cnt3), 0);
        drv3(1, 0, 0, 0, 8'h00); chk("l3.cnt_one", 32'(cnt3), 1);
        drv3(1, 0, 1, 1, 8'h00); chk("l3.a0.rdy", 32'(prdy3), 1); chk("l3.a0.pop", 32'(cpop3), 1);
        drv3(1, 0, 1, 1, 8'h00); chk("l3.a1.rdy", 32'(prdy3), 1); chk("l3.a1.pop", 32'(cpop3), 0);
        chk("l3.a1.cnt", 32'(cnt3), 0);
        drv3(1, 0, 1, 1, 8'h00); chk("l3.a2.rdy", 32'(prdy3), 1); chk("l3.a2.pop", 32'(cpop3), 0);
        drv3(1, 0, 0, 1, 8'h5A); chk("l3.a3.vld_early", 32'(rvld3), 0);
        drv3(1, 0, 0, 1, 8'h00); chk("l3.a4.vld", 32'(rvld3), 1); chk("l3.a4.err", 32'(rerr3), 0);
        chk("l3.a4.data", 32'(rdata3), 32'h5A);
        drv3(1, 0, 0, 1, 8'h00); chk("l3.a5.vld", 32'(rvld3), 1); chk("l3.a5.err", 32'(rerr3), 1);
        chk("l3.a5.data", 32'(rdata3), 0);
        drv3(1, 0, 0, 1, 8'h00); chk("l3.a6.vld", 32'(rvld3), 1); chk("l3.a6.err", 32'(rerr3), 1);
        drv3(1, 0, 0, 1, 8'h00); chk("l3.a7.vld", 32'(rvld3), 0);

        // Outstanding bound: consumer stalled, only DEPTH=4 accepts allowed
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            drv3(1, 0, 1, 0, 8'h00);
            if (prdy3 && pvld3) acc++;
        end
        chk("l3.outstanding", 32'(acc), 4);
        chk("l3.rdy_blocked", 32'(prdy3), 0);
        for (int k = 0; k < 4; k++) begin
            drv3(1, 0, 0, 1, 8'h00);
            chk($sformatf("l3.drain%0d.vld", k), 32'(rvld3), 1);
            chk($sformatf("l3.drain%0d.err", k), 32'(rerr3), 1);
        end
        drv3(1, 0, 0, 0, 8'h00); chk("l3.drained", 32'(rvld3), 0);

        // Reset with two responses buffered and one read in flight
        drv3(1, 1, 0, 0, 8'h00);
        drv3(1, 1, 0, 0, 8'h00);
        drv3(1, 0, 1, 0, 8'h00); chk("rst.c0.cnt", 32'(cnt3), 2); chk("rst.c0.pop", 32'(cpop3), 1);
        drv3(1, 0, 1, 0, 8'h00); chk("rst.c1.pop", 32'(cpop3), 1);
        drv3(1, 0, 1, 0, 8'h00); chk("rst.c2.pop", 32'(cpop3), 0); chk("rst.c2.rdy", 32'(prdy3), 1);
        drv3(1, 1, 0, 0, 8'h61);
        drv3(1, 0, 0, 0, 8'h62); chk("rst.c4.vld", 32'(rvld3), 1); chk("rst.c4.data", 32'(rdata3), 32'h61);
        chk("rst.c4.cnt", 32'(cnt3), 1);
        drv3(0, 0, 0, 0, 8'h63); chk("rst.c5.rdy_in_reset", 32'(prdy3), 0);
        for (int k = 0; k < 3; k++) begin
            drv3(1, 0, 0, 1, 8'hAA);
            chk($sformatf("rst.post%0d.vld", k), 32'(rvld3), 0);
            chk($sformatf("rst.post%0d.cnt", k), 32'(cnt3), 0);
            chk($sformatf("rst.post%0d.empty", k), 32'(empty3), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
